mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester ports (legal 1..8).
REQ-002 Parameter ADDR_W, default 18, significant address bits per port; mem_a bits above ADDR_W driven 0.
REQ-003 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-low.
REQ-005 rdy_in  input  1  high = run; low = pause.
REQ-006 req_in  input  NUM_PORTS  per-port request level, held until that port's done.
REQ-007 wr_in  input  NUM_PORTS  per-port direction (1 = write).
REQ-008 len_in  input  2*NUM_PORTS  per-port length: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
REQ-009 addr_in  input  ADDR_W*NUM_PORTS  per-port byte address.
REQ-010 wdata_in  input  32*NUM_PORTS  per-port write data, little-endian.
REQ-011 rdata_out  output  32  read result of last completed read, zero-extended.
REQ-012 done_out  output  NUM_PORTS  one-cycle completion pulse, owner port bit only.
REQ-013 grant_out  output  NUM_PORTS  one-hot current owner; 0 in IDLE.
REQ-014 busy_out  output  1  high whenever state is not IDLE.
REQ-015 mem_din  input  8; mem_dout  output  8; mem_a  output  32; mem_wr  output  1 (1 = write); io_buffer_full  input  1.

Function
REQ-016 States IDLE, READ, WRITE, DONE; all outputs registered.
REQ-017 IDLE: at edge G where any req_in bit is high and rdy_in high, select owner, latch its addr/len/wr/wdata, enter READ or WRITE, clear byte index.
REQ-018 Byte k (k = 0..L-1) address addr+k driven on mem_a in cycle G+1+k; address arithmetic wraps modulo 2^ADDR_W.
REQ-019 READ: mem_din sampled in cycle after its address; byte k placed in rdata bits [8k+7:8k]; unused upper bytes 0; done_out high in cycle G+L+2.
REQ-020 WRITE: byte k of wdata on mem_dout with mem_wr = 1 in cycle G+1+k; done_out high in cycle G+L+1.
REQ-021 mem_wr = 0 in every cycle that is not an issued write byte.
REQ-022 DONE lasts exactly one cycle, then IDLE; requester drops req_in at the edge ending DONE; a still-high req_in is treated as a new request.
REQ-023 IO stall: in WRITE, if addr[17:16] = 2'b11 and io_buffer_full high, byte not issued (mem_wr 0, index held); issue resumes the cycle after io_buffer_full falls.
REQ-024 Pause: while rdy_in low, all registers hold, mem_a held, mem_wr forced 0; a READ byte whose capture cycle falls in a pause is captured from mem_din in the first running cycle (mem_a unchanged, data valid).
REQ-025 req_in changes of non-owner ports during a transfer have no effect until next IDLE.

Reset
REQ-026 rst_in low at an edge: state IDLE, mem_a 0, mem_dout 0, mem_wr 0, rdata_out 0, done_out 0, grant_out 0, busy_out 0, priority pointer 0.
REQ-027 Reset mid-transfer abandons it; no done_out pulse issued for it; reset overrides rdy_in.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: round-robin; after granting port p pointer = (p+1) mod NUM_PORTS; winner = first requester at or after pointer, wrapping.
REQ-029 MEM_ARB_RR_EN undefined: fixed priority, lowest requesting index wins; pointer logic absent.

Verification
REQ-030 rst_in = 0 for 2 cycles mid-write -> mem_wr 0, mem_a 0, done_out 0, busy_out 0, no later done.
REQ-031 Port 0 read len 2 (4 bytes) at 0x00100, memory 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 in G+1..G+4, done_out = 2'b01 in G+6, rdata_out 0x44332211.
REQ-032 Port 1 write len 1 data 0x0000BEEF at 0x00200 -> G+1: mem_a 0x200, dout 0xEF, wr 1; G+2: 0x201, 0xBE, wr 1; done_out = 2'b10 in G+3.
REQ-033 Ports 0 and 1 re-request 1-byte reads continuously -> with MEM_ARB_RR_EN grants 0,1,0,1; without it 0,0,0,0.
REQ-034 Port 0 writes 0x41 to 0x30000 with io_buffer_full high 5 cycles -> no mem_wr for those cycles, single write cycle right after full falls, done next cycle.
REQ-035 rdy_in low 3 cycles during byte 1 of a 4-byte read -> done delayed by exactly 3 cycles, rdata_out unchanged from REQ-031 value.

Source files
------------

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_if
// Purpose  : Requester-side and memory-side bundle for the mem_arb arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arb_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 18
);
   logic                        rdy_in;
   logic [NUM_PORTS-1:0]        req_in;
   logic [NUM_PORTS-1:0]        wr_in;
   logic [2*NUM_PORTS-1:0]      len_in;
   logic [ADDR_W*NUM_PORTS-1:0] addr_in;
   logic [32*NUM_PORTS-1:0]     wdata_in;
   logic [31:0]                 rdata_out;
   logic [NUM_PORTS-1:0]        done_out;
   logic [NUM_PORTS-1:0]        grant_out;
   logic                        busy_out;
   logic [7:0]                  mem_din;
   logic [7:0]                  mem_dout;
   logic [31:0]                 mem_a;
   logic                        mem_wr;
   logic                        io_buffer_full;

   modport slave (
      input  rdy_in, req_in, wr_in, len_in, addr_in, wdata_in, mem_din, io_buffer_full,
      output rdata_out, done_out, grant_out, busy_out, mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy_in, req_in, wr_in, len_in, addr_in, wdata_in, mem_din, io_buffer_full,
      input  rdata_out, done_out, grant_out, busy_out, mem_dout, mem_a, mem_wr
   );
endinterface
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Purpose  : Multi-port byte-serial memory arbiter with IO-region write stall.
//            Define MEM_ARB_RR_EN for round-robin arbitration (fixed otherwise).
// Revision : 1.0
// ============================================================================
module mem_arb #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 18
) (
   input wire        clk_in,
   input wire        rst_in,
   mem_arb_if.slave  bus
);
   localparam int          c_IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [31:0] c_ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);
   localparam logic [1:0]  c_IO_REGION = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state,    w_state_nxt;
   logic [NUM_PORTS-1:0] r_grant,    w_grant_nxt;
   logic [NUM_PORTS-1:0] r_done,     w_done_nxt;
   logic                 r_busy,     w_busy_nxt;
   logic [31:0]          r_addr,     w_addr_nxt;
   logic [31:0]          r_wdata,    w_wdata_nxt;
   logic [2:0]           r_len,      w_len_nxt;
   logic [2:0]           r_idx,      w_idx_nxt;
   logic [31:0]          r_rbuf,     w_rbuf_nxt;
   logic [31:0]          r_rdata,    w_rdata_nxt;
   logic [31:0]          r_mem_a,    w_mem_a_nxt;
   logic [7:0]           r_mem_dout, w_mem_dout_nxt;
   logic                 r_mem_wr,   w_mem_wr_nxt;
`ifdef MEM_ARB_RR_EN
   logic [c_IDX_W-1:0]   r_ptr,      w_ptr_nxt;
`endif

   logic                 w_win_vld;
   logic [c_IDX_W-1:0]   w_win;
   logic [1:0]           w_new_len_code;
   logic [31:0]          w_new_addr;
   logic [31:0]          w_new_wdata;
   logic                 w_new_wr;
   logic                 w_new_stall;
   logic [31:0]          w_byte_addr;
   logic                 w_io_stall;
   logic [1:0]           w_cap;
   logic [31:0]          w_rbuf_ins;

   function automatic logic [2:0] len_bytes(input logic [1:0] code);
      case (code)
         2'd0:    len_bytes = 3'd1;
         2'd1:    len_bytes = 3'd2;
         default: len_bytes = 3'd4;
      endcase
   endfunction

   // Winner selection: scan from the pointer (round-robin) or from port 0.
   always_comb begin
      w_win     = '0;
      w_win_vld = 1'b0;
`ifdef MEM_ARB_RR_EN
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!w_win_vld && bus.req_in[(int'(r_ptr) + i) % NUM_PORTS]) begin
            w_win_vld = 1'b1;
            w_win     = c_IDX_W'((int'(r_ptr) + i) % NUM_PORTS);
         end
      end
`else
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (bus.req_in[i]) begin
            w_win_vld = 1'b1;
            w_win     = c_IDX_W'(i);
         end
      end
`endif
   end

   always_comb begin
      w_new_len_code = bus.len_in[2*int'(w_win) +: 2];
      w_new_addr     = 32'(bus.addr_in[ADDR_W*int'(w_win) +: ADDR_W]);
      w_new_wdata    = bus.wdata_in[32*int'(w_win) +: 32];
      w_new_wr       = bus.wr_in[w_win];
      w_new_stall    = (w_new_addr[17:16] == c_IO_REGION) && bus.io_buffer_full;
      w_byte_addr    = (r_addr + 32'(r_idx)) & c_ADDR_MASK;
      w_io_stall     = (w_byte_addr[17:16] == c_IO_REGION) && bus.io_buffer_full;
      // r_idx runs two ahead of the byte being captured during a read
      w_cap          = 2'(r_idx - 3'd2);
      w_rbuf_ins     = r_rbuf | (32'(bus.mem_din) << {w_cap, 3'b000});
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_done_nxt     = '0;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_len_nxt      = r_len;
      w_idx_nxt      = r_idx;
      w_rbuf_nxt     = r_rbuf;
      w_rdata_nxt    = r_rdata;
      w_mem_a_nxt    = r_mem_a;
      w_mem_dout_nxt = r_mem_dout;
      w_mem_wr_nxt   = 1'b0;
`ifdef MEM_ARB_RR_EN
      w_ptr_nxt      = r_ptr;
`endif

      if (bus.rdy_in) begin
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  w_grant_nxt        = '0;
                  w_grant_nxt[w_win] = 1'b1;
                  w_addr_nxt         = w_new_addr;
                  w_wdata_nxt        = w_new_wdata;
                  w_len_nxt          = len_bytes(w_new_len_code);
                  w_rbuf_nxt         = '0;
                  w_mem_a_nxt        = w_new_addr;
                  if (w_new_wr) begin
                     w_state_nxt = S_WRITE;
                     if (w_new_stall) begin
                        w_idx_nxt = 3'd0;
                     end else begin
                        w_mem_dout_nxt = w_new_wdata[7:0];
                        w_mem_wr_nxt   = 1'b1;
                        w_idx_nxt      = 3'd1;
                     end
                  end else begin
                     w_state_nxt = S_READ;
                     w_idx_nxt   = 3'd1;
                  end
`ifdef MEM_ARB_RR_EN
                  w_ptr_nxt = (w_win == c_IDX_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
`endif
               end
            end

            S_READ: begin
               w_idx_nxt = r_idx + 3'd1;
               if (r_idx < r_len) begin
                  w_mem_a_nxt = w_byte_addr;
               end
               if (r_idx >= 3'd2) begin
                  w_rbuf_nxt = w_rbuf_ins;
               end
               if (r_idx == r_len + 3'd1) begin
                  w_rdata_nxt = w_rbuf_ins;
                  w_done_nxt  = r_grant;
                  w_state_nxt = S_DONE;
               end
            end

            S_WRITE: begin
               if (r_idx == r_len) begin
                  w_done_nxt  = r_grant;
                  w_state_nxt = S_DONE;
               end else begin
                  w_mem_a_nxt = w_byte_addr;
                  if (!w_io_stall) begin
                     w_mem_dout_nxt = r_wdata[{r_idx[1:0], 3'b000} +: 8];
                     w_mem_wr_nxt   = 1'b1;
                     w_idx_nxt      = r_idx + 3'd1;
                  end
               end
            end

            S_DONE: begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
            end

            default: begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_done     <= '0;
         r_busy     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_rbuf     <= '0;
         r_rdata    <= '0;
         r_mem_a    <= '0;
         r_mem_dout <= '0;
         r_mem_wr   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         r_ptr      <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_done     <= w_done_nxt;
         r_busy     <= w_busy_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_len      <= w_len_nxt;
         r_idx      <= w_idx_nxt;
         r_rbuf     <= w_rbuf_nxt;
         r_rdata    <= w_rdata_nxt;
         r_mem_a    <= w_mem_a_nxt;
         r_mem_dout <= w_mem_dout_nxt;
         r_mem_wr   <= w_mem_wr_nxt;
`ifdef MEM_ARB_RR_EN
         r_ptr      <= w_ptr_nxt;
`endif
      end
   end

   assign bus.rdata_out = r_rdata;
   assign bus.done_out  = r_done;
   assign bus.grant_out = r_grant;
   assign bus.busy_out  = r_busy;
   assign bus.mem_a     = r_mem_a;
   assign bus.mem_dout  = r_mem_dout;
   assign bus.mem_wr    = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb
// Purpose  : Directed and randomized checks of mem_arb against a transfer-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_arb;
   localparam int NP     = 2;
   localparam int AW     = 18;
   localparam int MEM_SZ = 1 << AW;

   logic       clk;
   logic       rst_n;
   int         n_chk;
   int         n_fail;
   logic [7:0] mem [MEM_SZ];

   mem_arb_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

   mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory that stalls with rdy_in, so held read data stays valid.
   always @(posedge clk)
      if (bus.rdy_in) bus.mem_din <= mem[bus.mem_a[AW-1:0]];

   function automatic int nbytes(input logic [1:0] code);
      return (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] baddr(input logic [AW-1:0] a, input int k);
      return 32'((int'(a) + k) % MEM_SZ);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic wr, input logic [1:0] len,
                           input logic [AW-1:0] a, input logic [31:0] d);
      bus.wr_in[p]           = wr;
      bus.len_in[2*p +: 2]   = len;
      bus.addr_in[AW*p +: AW] = a;
      bus.wdata_in[32*p +: 32] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.rdy_in = 1'b1;
      bus.req_in = '0;
      bus.wr_in = '0;
      bus.len_in = '0;
      bus.addr_in = '0;
      bus.wdata_in = '0;
      bus.io_buffer_full = 1'b0;
      step();
      step();
      n_chk++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
      n_chk++; if (bus.grant_out !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", bus.grant_out); end
      n_chk++; if (bus.done_out !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_out); end
      n_chk++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
      n_chk++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
      n_chk++; if (bus.mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
      n_chk++; if (bus.rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_out); end
      rst_n = 1'b1;
      step();
      n_chk++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy_out); end
   endtask

   task automatic test_read_basic();
      mem[18'h00100] = 8'h11;
      mem[18'h00101] = 8'h22;
      mem[18'h00102] = 8'h33;
      mem[18'h00103] = 8'h44;
      set_port(0, 1'b0, 2'd2, 18'h00100, 32'h0);
      bus.req_in = 2'b01;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c <= 4) begin
            n_chk++; if (bus.mem_a !== 32'h100 + 32'(c - 1)) begin n_fail++; $display("FAIL rd_mem_a c%0d: got %h want %h", c, bus.mem_a, 32'h100 + 32'(c - 1)); end
         end
         n_chk++; if (bus.done_out !== ((c == 6) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rd_done c%0d: got %b", c, bus.done_out); end
         n_chk++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rd_mem_wr c%0d: got %b want 0", c, bus.mem_wr); end
         n_chk++; if (bus.grant_out !== ((c <= 6) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rd_grant c%0d: got %b", c, bus.grant_out); end
         if (c == 6) begin
            n_chk++; if (bus.rdata_out !== 32'h44332211) begin n_fail++; $display("FAIL rd_rdata: got %h want 44332211", bus.rdata_out); end
            bus.req_in = '0;
         end
      end
   endtask

   task automatic test_write_basic();
      set_port(1, 1'b1, 2'd1, 18'h00200, 32'h0000BEEF);
      bus.req_in = 2'b10;
      for (int c = 1; c <= 4; c++) begin
         step();
         n_chk++; if (bus.mem_wr !== (c <= 2)) begin n_fail++; $display("FAIL wr_mem_wr c%0d: got %b", c, bus.mem_wr); end
         if (c <= 2) begin
            n_chk++; if (bus.mem_a !== 32'h1FF + 32'(c)) begin n_fail++; $display("FAIL wr_mem_a c%0d: got %h want %h", c, bus.mem_a, 32'h1FF + 32'(c)); end
            n_chk++; if (bus.mem_dout !== ((c == 1) ? 8'hEF : 8'hBE)) begin n_fail++; $display("FAIL wr_dout c%0d: got %h", c, bus.mem_dout); end
         end
         n_chk++; if (bus.done_out !== ((c == 3) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL wr_done c%0d: got %b", c, bus.done_out); end
         if (c == 3) bus.req_in = '0;
      end
   endtask

   task automatic test_io_stall();
      set_port(0, 1'b1, 2'd0, 18'h30000, 32'h00000041);
      bus.io_buffer_full = 1'b1;
      bus.req_in = 2'b01;
      for (int c = 1; c <= 8; c++) begin
         step();
         n_chk++; if (bus.mem_wr !== (c == 6)) begin n_fail++; $display("FAIL io_mem_wr c%0d: got %b", c, bus.mem_wr); end
         if (c == 6) begin
            n_chk++; if (bus.mem_a !== 32'h30000) begin n_fail++; $display("FAIL io_mem_a: got %h want 30000", bus.mem_a); end
            n_chk++; if (bus.mem_dout !== 8'h41) begin n_fail++; $display("FAIL io_dout: got %h want 41", bus.mem_dout); end
         end
         n_chk++; if (bus.done_out !== ((c == 7) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL io_done c%0d: got %b", c, bus.done_out); end
         if (c == 5) bus.io_buffer_full = 1'b0;
         if (c == 7) bus.req_in = '0;
      end
   endtask

   task automatic test_random(input int n);
      int            p;
      int            len;
      int            dc;
      logic          wr;
      logic [1:0]    code;
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [31:0]   ba;
      logic [31:0]   exp_rd;
      logic [NP-1:0] oh;
      for (int t = 0; t < n; t++) begin
         p    = int'($urandom_range(NP - 1, 0));
         wr   = 1'($urandom_range(1, 0));
         code = 2'($urandom_range(3, 0));
         a    = (t % 4 == 0) ? AW'(MEM_SZ - 2) : AW'($urandom);
         d    = $urandom;
         len  = nbytes(code);
         oh   = NP'(1) << p;
         exp_rd = '0;
         if (!wr) begin
            for (int k = 0; k < len; k++) begin
               ba = baddr(a, k);
               mem[ba[AW-1:0]] = 8'($urandom);
               exp_rd = exp_rd | (32'(mem[ba[AW-1:0]]) << (8 * k));
            end
         end
         dc = wr ? len + 1 : len + 2;
         set_port(p, wr, code, a, d);
         bus.req_in = oh;
         for (int c = 1; c <= dc + 1; c++) begin
            step();
            n_chk++; if (bus.mem_wr !== (wr && c <= len)) begin n_fail++; $display("FAIL rnd%0d_mem_wr c%0d: got %b", t, c, bus.mem_wr); end
            if (c <= len) begin
               n_chk++; if (bus.mem_a !== baddr(a, c - 1)) begin n_fail++; $display("FAIL rnd%0d_mem_a c%0d: got %h want %h", t, c, bus.mem_a, baddr(a, c - 1)); end
               if (wr) begin
                  n_chk++; if (bus.mem_dout !== 8'(d >> (8 * (c - 1)))) begin n_fail++; $display("FAIL rnd%0d_dout c%0d: got %h want %h", t, c, bus.mem_dout, 8'(d >> (8 * (c - 1)))); end
               end
            end
            n_chk++; if (bus.done_out !== ((c == dc) ? oh : NP'(0))) begin n_fail++; $display("FAIL rnd%0d_done c%0d: got %b", t, c, bus.done_out); end
            n_chk++; if (bus.grant_out !== ((c <= dc) ? oh : NP'(0))) begin n_fail++; $display("FAIL rnd%0d_grant c%0d: got %b", t, c, bus.grant_out); end
            n_chk++; if (bus.busy_out !== (c <= dc)) begin n_fail++; $display("FAIL rnd%0d_busy c%0d: got %b", t, c, bus.busy_out); end
            if (c == dc) begin
               if (!wr) begin
                  n_chk++; if (bus.rdata_out !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", t, bus.rdata_out, exp_rd); end
               end
               bus.req_in = '0;
            end
         end
      end
   endtask

   task automatic test_pause();
      logic [31:0] exp_a;
      mem[18'h00100] = 8'h11;
      mem[18'h00101] = 8'h22;
      mem[18'h00102] = 8'h33;
      mem[18'h00103] = 8'h44;
      set_port(0, 1'b0, 2'd2, 18'h00100, 32'h0);
      bus.req_in = 2'b01;
      for (int c = 1; c <= 11; c++) begin
         step();
         exp_a = (c == 1) ? 32'h100 : (c <= 5) ? 32'h101 : (c == 6) ? 32'h102 : 32'h103;
         if (c <= 9) begin
            n_chk++; if (bus.mem_a !== exp_a) begin n_fail++; $display("FAIL pz_mem_a c%0d: got %h want %h", c, bus.mem_a, exp_a); end
         end
         n_chk++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL pz_mem_wr c%0d: got %b want 0", c, bus.mem_wr); end
         n_chk++; if (bus.done_out !== ((c == 9) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL pz_done c%0d: got %b", c, bus.done_out); end
         if (c == 9) begin
            n_chk++; if (bus.rdata_out !== 32'h44332211) begin n_fail++; $display("FAIL pz_rdata: got %h want 44332211", bus.rdata_out); end
            bus.req_in = '0;
         end
         if (c == 2) bus.rdy_in = 1'b0;
         if (c == 5) bus.rdy_in = 1'b1;
      end
   endtask

   task automatic test_reset_mid();
      set_port(0, 1'b1, 2'd2, 18'h01000, 32'hCAFEF00D);
      bus.req_in = 2'b01;
      step();
      step();
      n_chk++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL rm_pre_wr: got %b want 1", bus.mem_wr); end
      rst_n = 1'b0;
      bus.req_in = '0;
      for (int c = 1; c <= 2; c++) begin
         step();
         n_chk++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rm_mem_wr c%0d: got %b want 0", c, bus.mem_wr); end
         n_chk++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL rm_mem_a c%0d: got %h want 0", c, bus.mem_a); end
         n_chk++; if (bus.done_out !== '0) begin n_fail++; $display("FAIL rm_done c%0d: got %b want 0", c, bus.done_out); end
         n_chk++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL rm_busy c%0d: got %b want 0", c, bus.busy_out); end
         n_chk++; if (bus.grant_out !== '0) begin n_fail++; $display("FAIL rm_grant c%0d: got %b want 0", c, bus.grant_out); end
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         n_chk++; if (bus.done_out !== '0 || bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL rm_late c%0d: got done %b busy %b want 0 0", c, bus.done_out, bus.busy_out); end
      end
   endtask

   task automatic test_arbitration();
      int            got;
      int            exp_p;
      logic [NP-1:0] prev;
`ifdef MEM_ARB_RR_EN
      int            ptr;
      ptr = 0;
`endif
      got  = 0;
      prev = '0;
      set_port(0, 1'b0, 2'd0, 18'h00010, 32'h0);
      set_port(1, 1'b0, 2'd0, 18'h00020, 32'h0);
      bus.req_in = 2'b11;
      for (int c = 0; c < 60 && got < 4; c++) begin
         step();
         if (bus.grant_out !== '0 && prev === '0) begin
`ifdef MEM_ARB_RR_EN
            exp_p = ptr;
            ptr   = (ptr + 1) % NP;
`else
            exp_p = 0;
`endif
            n_chk++; if (bus.grant_out !== (NP'(1) << exp_p)) begin n_fail++; $display("FAIL arb_grant%0d: got %b want %b", got, bus.grant_out, NP'(1) << exp_p); end
            got++;
         end
         prev = bus.grant_out;
      end
      n_chk++; if (got != 4) begin n_fail++; $display("FAIL arb_count: got %0d grants want 4", got); end
      bus.req_in = '0;
      repeat (6) step();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_read_basic();
      test_write_basic();
      test_io_stall();
      test_random(24);
      test_pause();
      test_reset_mid();
      test_arbitration();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
